weight_loader: RTL and testbench

- Write-side initiator for one dual-port weight bank.
- Accepts a byte stream of quantised weights over a valid/ready handshake.
- Drives the bank's chip-select, write-enable, write-address, write-data and layer-select inputs, then signals completion to the layer controller.
- One instance sits in front of each weight bank.

---
 rtl/weight_loader.sv | 166 ++++++++++++++++
 tb/tb_weight_loader.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/weight_loader.sv
// weight_loader: write-side initiator for one dual-port weight bank.
// Accepts a valid/ready byte stream. Each accepted word is written to the bank
// one cycle later, at consecutive addresses starting from the latched
// start_addr. When the last word is written, a one-cycle done pulse goes to
// the layer controller.
// Optional feature: define WT_LOADER_CHKSUM_EN to add a 16-bit additive
// checksum. It is compared against exp_chksum in the DONE cycle.
module weight_loader #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 8,
  parameter int DATA_DEPTH = 2048
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [3:0]            layer_sel,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [ADDR_WIDTH:0]   load_len,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  s_ready,
  output logic                  mem_csen,
  output logic                  mem_wrenb,
  output logic [ADDR_WIDTH-1:0] mem_addr_b,
  output logic [DATA_WIDTH-1:0] mem_data_b,
  output logic [3:0]            mem_layer_cnt,
  output logic                  busy,
  output logic                  done,
  output logic                  err
`ifdef WT_LOADER_CHKSUM_EN
  ,
  input  logic [15:0]           exp_chksum,
  output logic                  chk_err
`endif
);

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DONE} state_t;

  localparam logic [ADDR_WIDTH+1:0] DEPTH_W = (ADDR_WIDTH+2)'(DATA_DEPTH);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE = (ADDR_WIDTH+1)'(1);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
  logic [ADDR_WIDTH:0]   len_q, len_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [3:0]            layer_q, layer_d;
  logic                  wr_q, wr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  err_q, err_d;
  logic                  hs;
  logic [ADDR_WIDTH+1:0] end_addr;
`ifdef WT_LOADER_CHKSUM_EN
  logic [15:0]           sum_q, sum_d;
  logic [15:0]           exp_q, exp_d;
`endif

  // Handshake and request bound: the end address is computed two bits wider,
  // so an out-of-range request cannot wrap and pass the check.
  assign hs       = s_valid && (state_q == LOAD);
  assign end_addr = {2'b00, start_addr} + {1'b0, load_len};

  // Next-state logic and next values of the datapath registers.
  always_comb begin
    // NOTE: every variable gets a default first, so no path can infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    base_d  = base_q;
    layer_d = layer_q;
    wr_d    = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    err_d   = 1'b0;
`ifdef WT_LOADER_CHKSUM_EN
    sum_d   = sum_q;
    exp_d   = exp_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (end_addr > DEPTH_W) begin
            err_d = 1'b1;
          end else begin
`ifdef WT_LOADER_CHKSUM_EN
            sum_d = '0;
            exp_d = exp_chksum;
`endif
            if (load_len == '0) begin
              state_d = DONE;
            end else begin
              layer_d = layer_sel;
              base_d  = start_addr;
              len_d   = load_len;
              cnt_d   = '0;
              state_d = LOAD;
            end
          end
        end
      end
      LOAD: begin
        if (hs) begin
          wr_d   = 1'b1;
          addr_d = base_q + cnt_q[ADDR_WIDTH-1:0];
          data_d = s_data;
          cnt_d  = cnt_q + CNT_ONE;
`ifdef WT_LOADER_CHKSUM_EN
          sum_d  = sum_q + 16'(s_data);
`endif
          if ((cnt_q + CNT_ONE) == len_q) state_d = FLUSH;
        end
      end
      FLUSH:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers. An asynchronous reset aborts any load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      base_q  <= '0;
      layer_q <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
`ifdef WT_LOADER_CHKSUM_EN
      sum_q   <= '0;
      exp_q   <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments make every flop sample pre-edge values.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      base_q  <= base_d;
      layer_q <= layer_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      err_q   <= err_d;
`ifdef WT_LOADER_CHKSUM_EN
      sum_q   <= sum_d;
      exp_q   <= exp_d;
`endif
    end
  end

  assign s_ready       = (state_q == LOAD);
  assign busy          = (state_q != IDLE);
  assign done          = (state_q == DONE);
  assign err           = err_q;
  assign mem_csen      = wr_q;
  assign mem_wrenb     = wr_q;
  assign mem_addr_b    = addr_q;
  assign mem_data_b    = data_q;
  assign mem_layer_cnt = layer_q;
`ifdef WT_LOADER_CHKSUM_EN
  assign chk_err       = (state_q == DONE) && (sum_q != exp_q);
`endif

endmodule

// File: tb/tb_weight_loader.sv
// Self-checking bench for weight_loader. A table of load descriptors is
// applied with their hand-computed results. Hand-written sequences cover
// reset, reset in mid-load, and a restart after that reset.
module tb_weight_loader;

  localparam int AW = 11;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [3:0]    layer_sel;
  logic [AW-1:0] start_addr;
  logic [AW:0]   load_len;
  logic          s_valid;
  logic [DW-1:0] s_data;
  logic          s_ready, mem_csen, mem_wrenb, busy, done, err;
  logic [AW-1:0] mem_addr_b;
  logic [DW-1:0] mem_data_b;
  logic [3:0]    mem_layer_cnt;
`ifdef WT_LOADER_CHKSUM_EN
  logic [15:0]   exp_chksum;
  logic          chk_err;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  weight_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DATA_DEPTH(2048)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .layer_sel(layer_sel),
    .start_addr(start_addr), .load_len(load_len), .s_valid(s_valid),
    .s_data(s_data), .s_ready(s_ready), .mem_csen(mem_csen),
    .mem_wrenb(mem_wrenb), .mem_addr_b(mem_addr_b), .mem_data_b(mem_data_b),
    .mem_layer_cnt(mem_layer_cnt), .busy(busy), .done(done), .err(err)
`ifdef WT_LOADER_CHKSUM_EN
    , .exp_chksum(exp_chksum), .chk_err(chk_err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]    layer;
    logic [AW-1:0] addr;
    logic [AW:0]   len;
    logic [15:0]   vpat;      // s_valid per cycle, bit 0 first
    logic [127:0]  data;      // word i in bits [8*i +: 8]
    int            poke;      // cycle at which a stray start is pulsed, -1 none
    bit            exp_err;
    logic [AW-1:0] last_addr;
    bit            chk_on;
    logic [15:0]   csum;
    bit            exp_chk;
  } vec_t;

  vec_t vecs[8];
  int   n_vec;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, " s_ready"}, 32'(s_ready), 0);
    check({tag, " wrenb"},   32'(mem_wrenb), 0);
    check({tag, " csen"},    32'(mem_csen), 0);
    check({tag, " busy"},    32'(busy), 0);
    check({tag, " done"},    32'(done), 0);
    check({tag, " err"},     32'(err), 0);
  endtask

  // Runs one descriptor: start, stream, then check the writes, done and busy.
  task automatic run_vec(input vec_t v, input int idx);
    int            hs_n = 0;
    int            cyc  = 0;
    bit            hs;
    logic [127:0]  dat;
    logic [DW-1:0] w;
    string         t;
    dat = v.data;
    t = $sformatf("v%0d", idx);
    @(negedge clk);
    start = 1'b1; layer_sel = v.layer; start_addr = v.addr; load_len = v.len;
`ifdef WT_LOADER_CHKSUM_EN
    exp_chksum = v.csum;
`endif
    @(negedge clk);
    start = 1'b0;
    if (v.exp_err) begin
      check({t, " err pulse"}, 32'(err), 1);
      check({t, " err busy"}, 32'(busy), 0);
      check({t, " err wrenb"}, 32'(mem_wrenb), 0);
      @(negedge clk);
      check({t, " err once"}, 32'(err), 0);
      check({t, " err busy2"}, 32'(busy), 0);
      check({t, " err wrenb2"}, 32'(mem_wrenb), 0);
      return;
    end
    if (v.len == 0) begin
      check({t, " len0 done"}, 32'(done), 1);
      check({t, " len0 busy"}, 32'(busy), 1);
      check({t, " len0 wrenb"}, 32'(mem_wrenb), 0);
`ifdef WT_LOADER_CHKSUM_EN
      if (v.chk_on) check({t, " len0 chk_err"}, 32'(chk_err), 32'(v.exp_chk));
`endif
      @(negedge clk);
      check({t, " len0 done end"}, 32'(done), 0);
      check({t, " len0 busy end"}, 32'(busy), 0);
      return;
    end
    while (hs_n < int'(v.len) && cyc < 40) begin
      check({t, " s_ready"}, 32'(s_ready), 1);
      check({t, " busy"}, 32'(busy), 1);
      check({t, " done early"}, 32'(done), 0);
      if (cyc == v.poke) begin
        start = 1'b1; layer_sel = 4'd9; start_addr = '0; load_len = 12'd1;
      end
      s_valid = v.vpat[cyc % 16];
      w = dat[hs_n*8 +: 8];
      s_data = w;
      hs = s_valid;
      @(negedge clk);
      start = 1'b0; s_valid = 1'b0;
      if (hs) begin
        check({t, " wrenb"}, 32'(mem_wrenb), 1);
        check({t, " csen"},  32'(mem_csen), 1);
        check({t, " addr"},  32'(mem_addr_b), 32'(v.addr) + 32'(hs_n));
        check({t, " data"},  32'(mem_data_b), 32'(w));
        hs_n++;
      end else begin
        check({t, " gap wrenb"}, 32'(mem_wrenb), 0);
        check({t, " gap csen"},  32'(mem_csen), 0);
      end
      cyc++;
    end
    check({t, " words written before timeout"}, 32'(hs_n), 32'(v.len));
    // Final-write (FLUSH) cycle.
    check({t, " flush s_ready"}, 32'(s_ready), 0);
    check({t, " last addr"}, 32'(mem_addr_b), 32'(v.last_addr));
    check({t, " layer"}, 32'(mem_layer_cnt), 32'(v.layer));
    check({t, " flush done"}, 32'(done), 0);
    @(negedge clk);
    check({t, " done"}, 32'(done), 1);
    check({t, " done busy"}, 32'(busy), 1);
    check({t, " done wrenb"}, 32'(mem_wrenb), 0);
`ifdef WT_LOADER_CHKSUM_EN
    if (v.chk_on) check({t, " chk_err"}, 32'(chk_err), 32'(v.exp_chk));
`endif
    @(negedge clk);
    check({t, " done pulse end"}, 32'(done), 0);
    check({t, " idle busy"}, 32'(busy), 0);
  endtask

  initial begin
    // layer, addr, len, vpat, data, poke, err, last_addr, chk_on, csum, exp_chk
    vecs[0] = '{4'd2, 11'd0,    12'd4, 16'hFFFF, 128'h44332211,        -1, 1'b0, 11'd3,    1'b0, 16'h0, 1'b0};
    vecs[1] = '{4'd3, 11'd100,  12'd3, 16'h0029, 128'hC3B2A1,          -1, 1'b0, 11'd102,  1'b0, 16'h0, 1'b0};
    vecs[2] = '{4'd1, 11'd2040, 12'd9, 16'hFFFF, 128'h0,               -1, 1'b1, 11'd0,    1'b0, 16'h0, 1'b0};
    vecs[3] = '{4'd4, 11'd2040, 12'd8, 16'hFFFF, 128'hF8F7F6F5F4F3F2F1, -1, 1'b0, 11'd2047, 1'b0, 16'h0, 1'b0};
    vecs[4] = '{4'd5, 11'd10,   12'd0, 16'hFFFF, 128'h0,               -1, 1'b0, 11'd0,    1'b0, 16'h0, 1'b0};
    vecs[5] = '{4'd7, 11'd500,  12'd3, 16'hFFFF, 128'h5A4B3C,           1, 1'b0, 11'd502,  1'b0, 16'h0, 1'b0};
    n_vec = 6;
`ifdef WT_LOADER_CHKSUM_EN
    vecs[6] = '{4'd6, 11'd200,  12'd3, 16'hFFFF, 128'h02FFFF,          -1, 1'b0, 11'd202,  1'b1, 16'h0200, 1'b0};
    vecs[7] = '{4'd6, 11'd300,  12'd3, 16'hFFFF, 128'h02FFFF,          -1, 1'b0, 11'd302,  1'b1, 16'h0201, 1'b1};
    n_vec = 8;
    exp_chksum = '0;
`endif

    rst_n = 1'b0; start = 1'b0; layer_sel = '0; start_addr = '0;
    load_len = '0; s_valid = 1'b0; s_data = '0;
    #1;
    check_idle_outputs("reset");
    check("reset addr", 32'(mem_addr_b), 0);
    check("reset data", 32'(mem_data_b), 0);
    check("reset layer", 32'(mem_layer_cnt), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < n_vec; i++) run_vec(vecs[i], i);

    // Reset after the 2nd of 5 words: outputs clear at once, no done follows.
    @(negedge clk);
    start = 1'b1; layer_sel = 4'd8; start_addr = 11'd300; load_len = 12'd5;
    @(negedge clk);
    start = 1'b0;
    s_valid = 1'b1; s_data = 8'hA0;
    @(negedge clk);
    s_data = 8'hA1;
    @(negedge clk);
    s_valid = 1'b0;
    check("pre-reset addr", 32'(mem_addr_b), 301);
    check("pre-reset wrenb", 32'(mem_wrenb), 1);
    rst_n = 1'b0;
    #1;
    check_idle_outputs("midload reset");
    check("midload reset addr", 32'(mem_addr_b), 0);
    check("midload reset data", 32'(mem_data_b), 0);
    check("midload reset layer", 32'(mem_layer_cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_idle_outputs("post reset");
    end

    // A fresh load after the reset behaves normally.
    run_vec(vecs[1], 10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Guard against a hung run.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
